ta_strip_writer: RTL and testbench
==================================

Name: ta_strip_writer

Overview:
- Tile-accelerator-side writer for the polygon parameter format that the ISP parser reads back.
- Takes a stream of 32-bit words: a 3-word header (ISP, TSP, TCW) followed by vertex words for one triangle strip.
- Writes the words sequentially into the VRAM parameter buffer.
- When the strip closes, emits the matching object-list pointer word (strip type, strip_mask, skip, parameter offset) to the OL builder.

Parameters:
- ADDR_W, 24, VRAM byte-address width.
- MAX_VERTS, 8, maximum vertices per strip (6 triangles); fixed by the strip_mask width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- param_base  in  ADDR_W  byte base of the parameter buffer, word aligned; sampled at reset release and on in_sop in IDLE
- param_limit  in  ADDR_W  first byte address past the buffer
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  32  header or vertex word
- in_sop  in  1  marks the ISP word (first header word)
- in_eos  in  1  marks the last word of the strip's last vertex
- ta_vram_wr  out  1  write strobe
- ta_vram_addr  out  ADDR_W  byte address
- ta_vram_dout  out  32  write data
- ta_vram_wait  in  1  VRAM stall; hold wr/addr/dout while high
- ol_entry_valid  out  1  one-cycle pulse
- ol_entry  out  32  object pointer word
- param_next  out  ADDR_W  next free parameter address
- err_fmt  out  1  sticky; format error
- err_overflow  out  1  sticky; vertex-count or buffer overflow

Behaviour:
- Reset values: in_ready=0, ta_vram_wr=0, ta_vram_addr=0, ta_vram_dout=0, ol_entry_valid=0, ol_entry=0, err_fmt=0, err_overflow=0, param_next=param_base.
- States: IDLE, HDR, VERT, DROP, EMIT.
- Word acceptance and writes:
  - in_ready = state!=EMIT && !(ta_vram_wr && ta_vram_wait).
  - A word accepted in cycle t drives ta_vram_wr/addr/dout in cycle t+1.
  - These are held while ta_vram_wait is high.
  - The address increments by 4 per written word.
  - DROP accepts words but never writes.
- IDLE:
  - A word with in_sop is accepted as ISP: latch entry_addr=param_next, go to HDR.
  - A word without in_sop is consumed, err_fmt is set, and the block stays in IDLE.
- HDR:
  - Accepts TSP then TCW.
  - An in_sop or in_eos on either of these -> err_fmt, go to DROP.
  - Otherwise go to VERT.
- Vertex length, from the latched ISP word: vert_words = 3 + (texture ? (uv_16_bit ? 1 : 2) : 0) + 1 + offset, where texture=isp[25], offset=isp[24], uv_16_bit=isp[22].
  - Range 4..7.
  - skip = vert_words-3 (3 bits).
- VERT:
  - word_cnt counts 0..vert_words-1; vert_cnt counts completed vertices.
  - A 9th vertex start -> err_overflow, go to DROP.
  - in_eos not on the last word of a vertex -> err_fmt, go to DROP.
  - in_sop in VERT -> err_fmt; the word is treated as a new ISP word (strip abandoned, new strip started).
  - in_eos with vert_cnt (including the current vertex) < 3 -> err_fmt.
    - param_next rewinds to entry_addr.
    - No entry is emitted; go to IDLE.
  - in_eos with N = 3..8 vertices -> EMIT.
- Buffer full: if a write address would be >= param_limit -> err_overflow, go to DROP, suppress that write.
- DROP:
  - Consumes words until in_eos, or until in_sop (treated as a new ISP word).
  - param_next rewinds to entry_addr; no entry is emitted.
- EMIT:
  - Waits until the final write completes (!ta_vram_wr || !ta_vram_wait).
  - Then pulses ol_entry_valid for 1 cycle with ol_entry = {1'b0, strip_mask[30:25], shadow=0, skip[23:21], word offset[20:0]}.
  - strip_mask sets N-2 bits from bit 30 downward (triangle 0 = bit 30).
  - Word offset = (entry_addr-param_base)>>2, truncated to 21 bits.
  - param_next = entry_addr + 4*(3 + N*vert_words).
  - Returns to IDLE the next cycle.
- Boundary rules:
  - Simultaneous in_sop and in_eos -> err_fmt.
  - Entry emission latency: 1 cycle after the final write is accepted by VRAM.
  - Reset mid-strip: all outputs go to reset values immediately, partial parameters are abandoned, param_next reloads param_base.

Decomposition:
- Shared pvr package:
  - ISP bit positions (texture, offset, gouraud, uv_16_bit).
  - OL pointer field positions (type bit 31, strip_mask 30:25, shadow 24, skip 23:21, addr 20:0).
  - vert_words function, shared with the ISP parser.
- Sub-module: ta_vert_len (combinational ISP -> vert_words/skip).
- Everything else stays in one FSM.

Test Plan:
- base 0x100000; ISP=0x00000000 (untextured, no offset); 3 verts x 4 words -> 15 writes 0x100000..0x100038; ol_entry=0x40200000; param_next=0x10003C.
- Follow-up strip: ISP=0x03000000 (textured, 32-bit UV, offset), 5 verts x 7 words -> ol_entry=0x7080000F; param_next=0x10003C+4*38=0x1000D4.
- ta_vram_wait high for 3 cycles mid-strip -> wr/addr/dout stable, in_ready=0, no word lost or duplicated, same ol_entry as the no-stall run.
- 9 vertices, untextured -> err_overflow=1; no entry; param_next unchanged; the next sop strip starts at the old param_next.
- in_eos on word 2 of a 4-word vertex -> err_fmt=1; no entry; rewind.
- param_limit=base+0x20 with a 15-word strip -> writes stop at base+0x1C; err_overflow=1; no entry.
- reset_n low mid-HDR -> all outputs 0 asynchronously; after release, a clean 3-vertex strip gives ol_entry=0x40200000.

Source files
------------

// File: rtl/ta_strip_writer_pkg.sv
// Shared PVR parameter-format definitions: ISP word fields, object-list pointer
// layout and the vertex-length rule used by both the TA writer and ISP parser.
package ta_strip_writer_pkg;

  localparam int ISP_TEXTURE = 25;
  localparam int ISP_OFFSET  = 24;
  localparam int ISP_GOURAUD = 23;
  localparam int ISP_UV16    = 22;

  localparam int OL_TYPE     = 31;
  localparam int OL_MASK_HI  = 30;
  localparam int OL_MASK_LO  = 25;
  localparam int OL_SHADOW   = 24;
  localparam int OL_SKIP_HI  = 23;
  localparam int OL_SKIP_LO  = 21;
  localparam int OL_ADDR_W   = 21;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_VERT, S_DROP, S_EMIT} state_t;

  // Only the ISP bits that change the vertex layout are kept per strip.
  typedef struct packed {
    logic texture;
    logic offset;
    logic uv_16_bit;
  } isp_mode_t;

  function automatic isp_mode_t isp_mode(input logic [31:0] isp);
    isp_mode_t m;
    m.texture   = isp[ISP_TEXTURE];
    m.offset    = isp[ISP_OFFSET];
    m.uv_16_bit = isp[ISP_UV16];
    return m;
  endfunction

  // xyz + optional uv (1 or 2 words) + base colour + optional offset colour.
  function automatic logic [2:0] calc_vert_words(input isp_mode_t m);
    logic [2:0] n;
    n = 3'd4;
    if (m.texture) n = n + (m.uv_16_bit ? 3'd1 : 3'd2);
    if (m.offset)  n = n + 3'd1;
    return n;
  endfunction

  // One bit per triangle, triangle 0 in the MSB of the 6-bit field.
  function automatic logic [5:0] strip_mask(input logic [3:0] n_verts);
    return 6'b111111 << (4'd8 - n_verts);
  endfunction

endpackage

// File: rtl/ta_vert_len.sv
// Combinational vertex-length decode: latched ISP mode -> words per vertex and
// the object-list skip field.
module ta_vert_len
  import ta_strip_writer_pkg::*;
(
  input  isp_mode_t  mode,
  output logic [2:0] vert_words,
  output logic [2:0] skip
);

  assign vert_words = calc_vert_words(mode);
  assign skip       = vert_words - 3'd3;

endmodule

// File: rtl/ta_strip_writer.sv
// Writes one triangle strip (ISP/TSP/TCW header + vertices) into the VRAM
// parameter buffer and emits the matching object-list pointer word.
module ta_strip_writer
  import ta_strip_writer_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int MAX_VERTS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] param_base,
  input  logic [ADDR_W-1:0] param_limit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eos,
  output logic              ta_vram_wr,
  output logic [ADDR_W-1:0] ta_vram_addr,
  output logic [31:0]       ta_vram_dout,
  input  logic              ta_vram_wait,
  output logic              ol_entry_valid,
  output logic [31:0]       ol_entry,
  output logic [ADDR_W-1:0] param_next,
  output logic              err_fmt,
  output logic              err_overflow
);

  state_t            state, state_n;
  logic              live;
  isp_mode_t         mode_q;
  logic              hdr_cnt;
  logic [2:0]        word_cnt;
  logic [3:0]        vert_cnt;
  logic [ADDR_W-1:0] entry_addr, base_q, wr_ptr, param_next_q, wr_addr;
  logic [2:0]        vert_words, skip;
  logic [31:0]       ol_word;
  logic              accept, start, wr_req, do_write, set_fmt, set_ovf, emit, last_word;

  ta_vert_len u_vert_len (
    .mode       (mode_q),
    .vert_words (vert_words),
    .skip       (skip)
  );

  // live stays low for the first cycle after reset so param_base is sampled
  // once it is stable; until then param_next simply mirrors the input.
  assign param_next = live ? param_next_q : param_base;
  assign in_ready   = live && (state != S_EMIT) && !(ta_vram_wr && ta_vram_wait);
  assign accept     = in_valid && in_ready;
  assign last_word  = (word_cnt == vert_words - 3'd1);

  always_comb begin
    ol_word                         = '0;
    ol_word[OL_TYPE]                = 1'b0;
    ol_word[OL_MASK_HI:OL_MASK_LO]  = strip_mask(vert_cnt);
    ol_word[OL_SHADOW]              = 1'b0;
    ol_word[OL_SKIP_HI:OL_SKIP_LO]  = skip;
    ol_word[OL_ADDR_W-1:0]          = OL_ADDR_W'((entry_addr - base_q) >> 2);
  end

  // NOTE: every signal assigned in this block gets a default first, otherwise
  // the paths that skip an assignment would infer latches.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    wr_req   = 1'b0;
    do_write = 1'b0;
    set_fmt  = 1'b0;
    set_ovf  = 1'b0;
    emit     = 1'b0;
    wr_addr  = wr_ptr;

    if (accept) begin
      if (in_sop && in_eos) begin
        set_fmt = 1'b1;
        state_n = S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (in_sop) start = 1'b1; else set_fmt = 1'b1;
          S_HDR: begin
            if (in_sop || in_eos) begin
              set_fmt = 1'b1;
              state_n = in_eos ? S_IDLE : S_DROP;
            end else begin
              wr_req = 1'b1;
            end
          end
          S_VERT: begin
            if (in_sop) begin
              set_fmt = 1'b1;
              start   = 1'b1;
            end else if (word_cnt == 3'd0 && vert_cnt == 4'(MAX_VERTS)) begin
              set_ovf = 1'b1;
              state_n = in_eos ? S_IDLE : S_DROP;
            end else if (in_eos && (!last_word || vert_cnt < 4'd2)) begin
              set_fmt = 1'b1;
              state_n = S_IDLE;
            end else begin
              wr_req = 1'b1;
            end
          end
          S_DROP: if (in_sop) start = 1'b1; else if (in_eos) state_n = S_IDLE;
          default: ;
        endcase
      end

      // A new ISP always lands at param_next, which still equals the entry
      // address of any strip being abandoned.
      if (start) begin
        wr_req  = 1'b1;
        wr_addr = param_next;
        state_n = S_HDR;
      end

      if (wr_req) begin
        if (wr_addr >= param_limit) begin
          set_ovf = 1'b1;
          state_n = in_eos ? S_IDLE : S_DROP;
        end else begin
          do_write = 1'b1;
          if (state == S_HDR && hdr_cnt) state_n = S_VERT;
          if (state == S_VERT && in_eos) state_n = S_EMIT;
        end
      end
    end

    if (state == S_EMIT && (!ta_vram_wr || !ta_vram_wait)) begin
      emit    = 1'b1;
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live           <= 1'b0;
      mode_q         <= '0;
      hdr_cnt        <= 1'b0;
      word_cnt       <= '0;
      vert_cnt       <= '0;
      entry_addr     <= '0;
      base_q         <= '0;
      wr_ptr         <= '0;
      param_next_q   <= '0;
      ta_vram_wr     <= 1'b0;
      ta_vram_addr   <= '0;
      ta_vram_dout   <= '0;
      ol_entry_valid <= 1'b0;
      ol_entry       <= '0;
      err_fmt        <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      live           <= 1'b1;
      ol_entry_valid <= emit;
      if (!live) begin
        base_q       <= param_base;
        param_next_q <= param_base;
      end
      if (set_fmt) err_fmt      <= 1'b1;
      if (set_ovf) err_overflow <= 1'b1;

      if (start) begin
        mode_q     <= isp_mode(in_data);
        entry_addr <= param_next;
        hdr_cnt    <= 1'b0;
        word_cnt   <= '0;
        vert_cnt   <= '0;
        if (state == S_IDLE) base_q <= param_base;
      end

      if (do_write) begin
        ta_vram_wr   <= 1'b1;
        ta_vram_addr <= wr_addr;
        ta_vram_dout <= in_data;
        wr_ptr       <= wr_addr + ADDR_W'(4);
        if (state == S_HDR) hdr_cnt <= 1'b1;
        if (state == S_VERT && !start) begin
          if (last_word) begin
            word_cnt <= '0;
            vert_cnt <= vert_cnt + 4'd1;
          end else begin
            word_cnt <= word_cnt + 3'd1;
          end
        end
      end else if (!ta_vram_wait) begin
        ta_vram_wr <= 1'b0;
      end

      // wr_ptr now sits one word past the final write, i.e.
      // entry_addr + 4*(3 + N*vert_words).
      if (emit) begin
        ol_entry     <= ol_word;
        param_next_q <= wr_ptr;
      end
    end
  end

endmodule

// File: tb/tb_ta_strip_writer.sv
// Scoreboard bench for ta_strip_writer: drivers queue expected VRAM writes and
// object-list entries, a monitor pops and compares them as the DUT emits.
module tb_ta_strip_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] param_base, param_limit, param_next;
  logic        in_valid, in_ready, in_sop, in_eos;
  logic [31:0] in_data;
  logic        ta_vram_wr, ta_vram_wait;
  logic [23:0] ta_vram_addr;
  logic [31:0] ta_vram_dout;
  logic        ol_entry_valid;
  logic [31:0] ol_entry;
  logic        err_fmt, err_overflow;

  int checks   = 0;
  int failures = 0;
  logic [55:0] wq[$];
  logic [31:0] oq[$];

  always #5 clock = ~clock;

  ta_strip_writer #(.ADDR_W(24), .MAX_VERTS(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .param_base     (param_base),
    .param_limit    (param_limit),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sop         (in_sop),
    .in_eos         (in_eos),
    .ta_vram_wr     (ta_vram_wr),
    .ta_vram_addr   (ta_vram_addr),
    .ta_vram_dout   (ta_vram_dout),
    .ta_vram_wait   (ta_vram_wait),
    .ol_entry_valid (ol_entry_valid),
    .ol_entry       (ol_entry),
    .param_next     (param_next),
    .err_fmt        (err_fmt),
    .err_overflow   (err_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a write counts at the edge where wr is high and wait is low.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (ta_vram_wr && !ta_vram_wait) begin
          if (wq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                     ta_vram_addr, ta_vram_dout);
          end else begin
            check("vram_write", {ta_vram_addr, ta_vram_dout}, wq.pop_front());
          end
        end
        if (ol_entry_valid) begin
          if (oq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ol_entry: got 0x%0h, none expected", ol_entry);
          end else begin
            check("ol_entry", ol_entry, oq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic sop, input logic eos,
                     input bit wr_exp, input logic [23:0] a);
    bit done;
    done = 1'b0;
    if (wr_exp) wq.push_back({a, d});
    in_data  = d;
    in_sop   = sop;
    in_eos   = eos;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL put_timeout: word 0x%0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eos   = 1'b0;
  endtask

  // Sends a full strip; only the first nwrite words are expected in VRAM.
  task automatic send_strip(input logic [31:0] isp, input int nv, input int vw,
                            input logic [7:0] tag, input logic [23:0] start,
                            input int nwrite, input bit ol_exp, input logic [31:0] ol);
    int total;
    total = 3 + nv * vw;
    if (ol_exp) oq.push_back(ol);
    for (int k = 0; k < total; k++)
      put((k == 0) ? isp : {8'hC0, tag, 16'(k)}, k == 0, k == total - 1,
          k < nwrite, start + 24'(4 * k));
    idle_inputs();
  endtask

  task automatic drain();
    cyc(6);
    for (int i = 0; i < 100 && (wq.size() != 0 || oq.size() != 0); i++) @(negedge clock);
    check("writes_drained", wq.size(), 0);
    check("entries_drained", oq.size(), 0);
    cyc(1);
  endtask

  initial begin
    reset_n      = 1'b0;
    param_base   = 24'h100000;
    param_limit  = 24'h200000;
    ta_vram_wait = 1'b0;
    in_data      = '0;
    idle_inputs();
    #1;
    check("reset_ctrl", {in_ready, ta_vram_wr, ol_entry_valid, err_fmt, err_overflow}, 0);
    check("reset_addr_dout", {ta_vram_addr, ta_vram_dout}, 0);
    check("reset_ol_entry", ol_entry, 0);
    check("reset_param_next", param_next, 24'h100000);
    cyc(2);
    reset_n = 1'b1;

    // Untextured 3-vertex strip at the buffer base.
    send_strip(32'h0000_0000, 3, 4, 8'h0A, 24'h100000, 15, 1'b1, 32'h4020_0000);
    drain();
    check("strip_a_param_next", param_next, 24'h10003C);
    check("strip_a_errors", {err_fmt, err_overflow}, 2'b00);

    // Textured, 32-bit UV, offset colour: 7 words per vertex, 5 vertices.
    send_strip(32'h0300_0000, 5, 7, 8'h0B, 24'h10003C, 38, 1'b1, 32'h7080_000F);
    drain();
    check("strip_b_param_next", param_next, 24'h1000D4);

    // Ninth vertex overflows; the strip is dropped.
    send_strip(32'h0000_0000, 9, 4, 8'h0C, 24'h1000D4, 35, 1'b0, 32'h0);
    drain();
    check("nine_vert_errors", {err_fmt, err_overflow}, 2'b01);
    check("nine_vert_param_next", param_next, 24'h1000D4);

    // Next strip reuses the abandoned slot.
    send_strip(32'h0000_0000, 3, 4, 8'h0D, 24'h1000D4, 15, 1'b1, 32'h4020_0035);
    drain();
    check("after_ovf_param_next", param_next, 24'h100110);

    // in_eos on the third word of a 4-word vertex.
    put(32'h0000_0000, 1'b1, 1'b0, 1'b1, 24'h100110);
    put(32'hAA00_0001, 1'b0, 1'b0, 1'b1, 24'h100114);
    put(32'hAA00_0002, 1'b0, 1'b0, 1'b1, 24'h100118);
    put(32'hAA00_0003, 1'b0, 1'b0, 1'b1, 24'h10011C);
    put(32'hAA00_0004, 1'b0, 1'b0, 1'b1, 24'h100120);
    put(32'hAA00_0005, 1'b0, 1'b1, 1'b0, 24'h0);
    idle_inputs();
    drain();
    check("early_eos_errors", {err_fmt, err_overflow}, 2'b11);
    check("early_eos_param_next", param_next, 24'h100110);

    // Reset while in HDR: the TSP write in flight is abandoned.
    put(32'h0000_0000, 1'b1, 1'b0, 1'b1, 24'h100110);
    put(32'hBB00_0001, 1'b0, 1'b0, 1'b0, 24'h0);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("midhdr_reset_ctrl", {in_ready, ta_vram_wr, ol_entry_valid, err_fmt, err_overflow}, 0);
    check("midhdr_reset_addr_dout", {ta_vram_addr, ta_vram_dout}, 0);
    check("midhdr_reset_ol_entry", ol_entry, 0);
    check("midhdr_reset_param_next", param_next, 24'h100000);
    check("midhdr_reset_wq", wq.size(), 0);
    cyc(2);
    reset_n = 1'b1;

    // Clean strip after reset with a 3-cycle VRAM stall mid-strip.
    fork
      send_strip(32'h0000_0000, 3, 4, 8'h0E, 24'h100000, 15, 1'b1, 32'h4020_0000);
      begin : stall_proc
        bit seen;
        logic [55:0] cap;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clock);
          seen = ta_vram_wr && (ta_vram_addr == 24'h100010);
        end
        check("stall_trigger", 64'(seen), 1);
        @(posedge clock);
        #1;
        ta_vram_wait = 1'b1;
        @(negedge clock);
        cap = {ta_vram_addr, ta_vram_dout};
        check("stall_wr_high", ta_vram_wr, 1);
        check("stall_in_ready", in_ready, 0);
        repeat (2) begin
          @(negedge clock);
          check("stall_hold", {ta_vram_wr, ta_vram_addr, ta_vram_dout}, {1'b1, cap});
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        ta_vram_wait = 1'b0;
      end
    join
    drain();
    check("stall_param_next", param_next, 24'h10003C);
    check("stall_errors", {err_fmt, err_overflow}, 2'b00);

    // Buffer limit at base+0x20: only 8 words fit.
    reset_n = 1'b0;
    cyc(2);
    param_limit = 24'h100020;
    reset_n = 1'b1;
    send_strip(32'h0000_0000, 3, 4, 8'h0F, 24'h100000, 8, 1'b0, 32'h0);
    drain();
    check("limit_errors", {err_fmt, err_overflow}, 2'b01);
    check("limit_param_next", param_next, 24'h100000);

    // A word without in_sop in IDLE is a format error.
    param_limit = 24'h200000;
    put(32'h1234_5678, 1'b0, 1'b0, 1'b0, 24'h0);
    idle_inputs();
    drain();
    check("idle_nosop_errors", {err_fmt, err_overflow}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
